// File: rtl/multi_ch_fifo_arbiter.sv
// Multi-channel FIFO read arbiter.
// Pops words from CHANNELS first-word-fall-through sources into one registered output stage.
// Two arbitration schemes are available: round-robin with bursting, or fixed priority.
// The output stage accepts a new word whenever it is empty or being drained.
// Grant latency is one cycle, so sustained throughput is one word per cycle.
module multi_ch_fifo_arbiter #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned TAG_EN    = 0,
  localparam int unsigned IDW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      BUS_CLK,
  input  logic                      RESETB,
  input  logic [CHANNELS-1:0]       READ_REQ,
  input  logic [CHANNELS*WIDTH-1:0] DATA_IN,
  output logic [CHANNELS-1:0]       READ_ACK,
  input  logic [CHANNELS-1:0]       ENABLE,
  input  logic                      PRIORITY_MODE,
  output logic                      WRITE_OUT,
  output logic [WIDTH-1:0]          DATA_OUT,
  input  logic                      READY_OUT,
  output logic [IDW-1:0]            GRANT_OUT
);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             armed_q;
  logic             write_q, write_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]   grant_q, grant_d;

  logic [CHANNELS-1:0] eligible;
  logic                any_elig;
  logic                loadable;
  logic                do_load;
  logic                last_elig;
  logic [IDW-1:0]      rr_pick;
  logic [IDW-1:0]      fp_pick;
  logic [IDW-1:0]      rr_hi;
  logic [IDW-1:0]      rr_lo;
  logic                rr_hi_found;

  assign eligible = READ_REQ & ENABLE;
  assign any_elig = |eligible;
  // armed_q blocks loads in the first cycle after reset release
  assign loadable = armed_q && (!write_q || READY_OUT);
  assign do_load  = loadable && any_elig;

  // Candidate search: fixed priority, round-robin after LAST, and LAST's own eligibility
  always_comb begin
    fp_pick     = '0;
    rr_hi       = '0;
    rr_lo       = '0;
    rr_hi_found = 1'b0;
    last_elig   = 1'b0;
    // Descending scan so the lowest matching index is the one that sticks
    for (int c = int'(CHANNELS) - 1; c >= 0; c--) begin
      if (eligible[c]) begin
        fp_pick = IDW'(c);
        if (IDW'(c) > last_q) begin
          rr_hi       = IDW'(c);
          rr_hi_found = 1'b1;
        end else begin
          rr_lo = IDW'(c);
        end
        if (IDW'(c) == last_q) begin
          last_elig = 1'b1;
        end
      end
    end
    // Channels above LAST come first; otherwise wrap around, reaching LAST itself last
    rr_pick = rr_hi_found ? rr_hi : rr_lo;
  end

  // Next-state: arbitration decision, burst bookkeeping and output stage load
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    data_d  = data_q;
    grant_d = grant_q;
    if (loadable) begin
      if (!any_elig) begin
        write_d = 1'b0;
        state_d = StIdle;
      end else begin
        write_d = 1'b1;
        if (PRIORITY_MODE) begin
          grant_d = fp_pick;
          last_d  = fp_pick;
        end else if (state_q == StBurst && last_elig && 32'(cnt_q) < MAX_BURST) begin
          grant_d = last_q;
          cnt_d   = cnt_q + 8'd1;
        end else begin
          grant_d = rr_pick;
          last_d  = rr_pick;
          cnt_d   = 8'd1;
          state_d = StBurst;
        end
        data_d = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
          if (IDW'(c) == grant_d) begin
            data_d = DATA_IN[c*WIDTH +: WIDTH];
          end
        end
        if (TAG_EN != 0) begin
          data_d[WIDTH-1 -: IDW] = grant_d;
        end
      end
    end
    // Fixed priority has no burst tracking
    if (PRIORITY_MODE) begin
      state_d = StIdle;
    end
  end

  // State and output registers
  always_ff @(posedge BUS_CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q <= StIdle;
      last_q  <= IDW'(CHANNELS - 1);
      cnt_q   <= 8'd0;
      armed_q <= 1'b0;
      write_q <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      armed_q <= 1'b1;
      write_q <= write_d;
      data_q  <= data_d;
      grant_q <= grant_d;
    end
  end

  // Pop strobe to the granted channel, only in a cycle that actually loads
  always_comb begin
    READ_ACK = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      READ_ACK[c] = do_load && (grant_d == IDW'(c));
    end
  end

  assign WRITE_OUT = write_q;
  assign DATA_OUT  = data_q;
  assign GRANT_OUT = grant_q;

endmodule
